// File: rtl/mcycle_ctrl.sv
// Sequencer for the iterative MUL/DIV datapath; Done at WIDTH+1 (MUL), WIDTH+2 (DIV), 1 (DIV by zero).
// Stalls the pipeline via Busy while running; Flush aborts RUN/FIX without Done, a committed DONE is never cancelled.
module mcycle_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic             Flush,
    input  logic [WIDTH-1:0] Operand2,
    output logic             Busy,
    output logic             Load,
    output logic             Step,
    output logic             Fix,
    output logic [CNT_W-1:0] Count,
    output logic             Op_Latched,
    output logic             Div_By_Zero,
    output logic             Done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             r_op;
    logic             r_dbz;
    logic             w_dbz;
    logic             w_busy;
    logic             w_load;
    logic             w_step;
    logic             w_fix;
    logic             w_done;

    assign w_dbz = MCycleOp & (Operand2 == '0);

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = Start & ~Flush;
                w_busy = w_load;
                if (w_load)
                    w_next = w_dbz ? DONE : RUN;
            end
            RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (Flush)
                    w_next = IDLE;
                else if (r_count == LAST)
                    w_next = r_op ? FIX : DONE;
            end
            FIX: begin
                w_busy = 1'b1;
                w_fix  = 1'b1;
                w_next = Flush ? IDLE : DONE;
            end
            DONE: begin
                // Start is deliberately ignored here so a held Start cannot retrigger.
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_count <= '0;
            r_op    <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_op    <= MCycleOp;
                r_count <= '0;
                r_dbz   <= w_dbz;
            end else if (w_step && (r_count != LAST)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Combinational strobes are masked so every output reads 0 while RESET is high.
    assign Busy        = w_busy & ~RESET;
    assign Load        = w_load & ~RESET;
    assign Step        = w_step & ~RESET;
    assign Fix         = w_fix  & ~RESET;
    assign Done        = w_done & ~RESET;
    assign Count       = r_count;
    assign Op_Latched  = r_op;
    assign Div_By_Zero = r_dbz;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Scoreboard bench for mcycle_ctrl: WIDTH=32 instance with directed + random operations, WIDTH=8 instance for back-to-back MULs.
`timescale 1ns/1ps
module tb_mcycle_ctrl;

    localparam int W   = 32;
    localparam int CW  = 5;
    localparam int W8  = 8;
    localparam int CW8 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start, op, flush;
    logic [W-1:0]  opnd;
    logic          busy, load, step, fix, opl, dbz, done;
    logic [CW-1:0] count;

    logic           start8, op8, flush8;
    logic [W8-1:0]  opnd8;
    logic           busy8, load8, step8, fix8, opl8, dbz8, done8;
    logic [CW8-1:0] count8;

    mcycle_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK(clk), .RESET(rst), .Start(start), .MCycleOp(op), .Flush(flush),
        .Operand2(opnd), .Busy(busy), .Load(load), .Step(step), .Fix(fix),
        .Count(count), .Op_Latched(opl), .Div_By_Zero(dbz), .Done(done)
    );

    mcycle_ctrl #(.WIDTH(W8), .CNT_W(CW8)) dut8 (
        .CLK(clk), .RESET(rst), .Start(start8), .MCycleOp(op8), .Flush(flush8),
        .Operand2(opnd8), .Busy(busy8), .Load(load8), .Step(step8), .Fix(fix8),
        .Count(count8), .Op_Latched(opl8), .Div_By_Zero(dbz8), .Done(done8)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int cyc; bit op; } ld_t;
    typedef struct { int cyc; bit dbz; bit op; int steps; int fixes; int busy; } dn_t;

    ld_t ldq[$];
    dn_t dnq[$];
    int  ld8q[$];
    int  dn8q[$];

    // Monitor for the WIDTH=32 instance.
    int  steps_seen = 0, fix_seen = 0, busy_seen = 0;
    bit  cur_op = 1'b0;
    always @(negedge clk) begin
        ld_t l;
        dn_t d;
        if (rst) begin
            chk("reset_outputs", {busy, load, step, fix, done, opl, dbz, count}, 0);
        end else begin
            chk("mutex", ($countones({load, step, fix, done}) <= 1), 1);
            chk("count_range", (count <= W - 1), 1);
            if (load) begin
                if (ldq.size() == 0) chk("unexpected_load", cyc, -1);
                else begin
                    l = ldq.pop_front();
                    chk("load_cycle", cyc, l.cyc);
                    cur_op = l.op;
                end
                steps_seen = 0; fix_seen = 0; busy_seen = 0;
            end
            if (busy) busy_seen++;
            if (step) begin
                chk("step_count", count, steps_seen);
                chk("step_op_latched", opl, cur_op);
                steps_seen++;
            end
            if (fix) fix_seen++;
            if (done) begin
                if (dnq.size() == 0) chk("unexpected_done", cyc, -1);
                else begin
                    d = dnq.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("done_dbz", dbz, d.dbz);
                    chk("done_op_latched", opl, d.op);
                    chk("done_steps", steps_seen, d.steps);
                    chk("done_fixes", fix_seen, d.fixes);
                    chk("done_busy_cycles", busy_seen, d.busy);
                end
            end
        end
    end

    // Monitor for the WIDTH=8 instance.
    int idx8 = 0;
    always @(negedge clk) begin
        int e;
        if (!rst) begin
            chk("w8_count_range", (count8 <= W8 - 1), 1);
            if (load8) begin
                if (ld8q.size() == 0) chk("w8_unexpected_load", cyc, -1);
                else begin e = ld8q.pop_front(); chk("w8_load_cycle", cyc, e); end
                idx8 = 0;
            end
            if (step8) begin
                chk("w8_step_count", count8, idx8);
                idx8++;
            end
            if (done8) begin
                if (dn8q.size() == 0) chk("w8_unexpected_done", cyc, -1);
                else begin
                    e = dn8q.pop_front();
                    chk("w8_done_cycle", cyc, e);
                    chk("w8_done_steps", idx8, W8);
                end
            end
        end
    end

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int latency(input bit o, input logic [W-1:0] v);
        if (o && (v == 0)) return 1;
        return W + 1 + int'(o);
    endfunction

    // Issues one operation from the current cycle; flush_rel/rst_at are cycles relative to Load (-1 = none).
    task automatic do_op(input bit o, input logic [W-1:0] v, input int flush_rel, input int gap, input int rst_at);
        int  L, lat;
        bit  z, aborted;
        z   = o && (v == 0);
        lat = latency(o, v);
        start = 1'b1; op = o; opnd = v; flush = (flush_rel == 0);
        if (flush_rel == 0) begin
            step_cyc();
            flush = 1'b0;
        end
        L = cyc;
        ldq.push_back('{L, o});
        aborted = (flush_rel >= 1 && flush_rel < lat) || (rst_at >= 1 && rst_at < lat);
        if (!aborted)
            dnq.push_back('{L + lat, z, o, z ? 0 : W, (o && !z) ? 1 : 0, lat});
        for (int k = 1; k <= lat; k++) begin
            step_cyc();
            if (k == rst_at) begin
                #2;
                rst = 1'b1;
                #1;
                chk("async_reset_strobes", {busy, load, step, fix, done}, 0);
                chk("async_reset_regs", {opl, dbz}, 0);
                chk("async_reset_count", count, 0);
                step_cyc();
                rst = 1'b0;
                flush = 1'b0;
                return;
            end
            flush = (k == flush_rel);
            if (k == flush_rel && k < lat) begin
                step_cyc();
                flush = 1'b0;
                start = 1'b0;
                repeat (gap) step_cyc();
                return;
            end
        end
        step_cyc();
        start = 1'b0;
        flush = 1'b0;
        repeat (gap) step_cyc();
    endtask

    initial begin
        int L8;
        rst = 1'b1; start = 1'b1; op = 1'b1; flush = 1'b0; opnd = '0;
        start8 = 1'b1; op8 = 1'b0; flush8 = 1'b0; opnd8 = 8'd3;
        #2;
        chk("reset_comb_busy_load", {busy, load}, 0);
        chk("reset_w8_outputs", {busy8, load8, step8, fix8, done8, opl8, dbz8, count8}, 0);
        step_cyc();
        step_cyc();
        start = 1'b0; start8 = 1'b0;
        rst = 1'b0;
        step_cyc();
        chk("idle_no_busy", busy, 0);

        do_op(1'b0, 32'h1234_5678, -1, 1, -1);   // MUL, Start dropped after Done
        do_op(1'b1, 32'd7,         -1, 1, -1);   // DIV
        do_op(1'b1, 32'd0,         -1, 1, -1);   // DIV by zero
        do_op(1'b0, 32'd9,         10, 1, -1);   // MUL flushed at cycle 10, restart at 12
        do_op(1'b0, 32'd3,         -1, 0, -1);   // back-to-back into next
        do_op(1'b1, 32'd5,         -1, 0,  5);   // reset mid DIV, Start kept high
        do_op(1'b0, 32'd1,         33, 0, -1);   // flush during DONE still completes
        do_op(1'b1, 32'd2,          0, 1, -1);   // flush with Start in IDLE not accepted
        do_op(1'b1, 32'd11,        33, 2, -1);   // flush in FIX aborts

        repeat (40) begin
            bit            o;
            logic [W-1:0]  v;
            int            lat, fr, sel;
            o   = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            lat = latency(o, v);
            sel = $urandom_range(0, 5);
            fr  = -1;
            if (sel == 0) fr = 0;
            else if (sel == 1 && lat > 1) fr = $urandom_range(1, lat - 1);
            else if (sel == 2) fr = lat;
            do_op(o, v, fr, $urandom_range(0, 2), -1);
        end

        step_cyc();
        L8 = cyc;
        start8 = 1'b1;
        ld8q.push_back(L8);
        ld8q.push_back(L8 + W8 + 2);
        dn8q.push_back(L8 + W8 + 1);
        dn8q.push_back(L8 + 2 * W8 + 3);
        repeat (2 * W8 + 4) step_cyc();
        start8 = 1'b0;

        repeat (5) step_cyc();
        chk("pending_loads", ldq.size(), 0);
        chk("pending_dones", dnq.size(), 0);
        chk("w8_pending_loads", ld8q.size(), 0);
        chk("w8_pending_dones", dn8q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
